// File: rtl/branch_predictor.sv
// Saturating-counter branch predictor with resolved-branch and misprediction statistics.
// Define BP_GSHARE_EN to XOR a global history register into the table index (gshare).
module branch_predictor #(
  parameter int ENTRIES    = 32,
  parameter int CTR_WIDTH  = 2,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bp_enable,
  input  logic [31:0]           guess_pc,
  input  logic                  guess_valid,
  output logic                  guess_taken,
  input  logic [31:0]           check_pc,
  input  logic                  check_valid,
  input  logic                  check_taken,
  input  logic                  check_pred,
  output logic                  mispredict,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CTR_WIDTH-1:0]  CTR_MAX     = '1;
  localparam logic [CTR_WIDTH-1:0]  CTR_ZERO    = '0;
  localparam logic [CTR_WIDTH-1:0]  CTR_ONE     = {{(CTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CTR_WIDTH-1:0]  CTR_WEAK_NT = {1'b0, {(CTR_WIDTH-1){1'b1}}};
  localparam logic [STAT_WIDTH-1:0] STAT_MAX    = '1;
  localparam logic [STAT_WIDTH-1:0] STAT_ONE    = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  // Move a counter one step toward the resolved outcome, holding at either end.
  function automatic logic [CTR_WIDTH-1:0] ctr_next(input logic [CTR_WIDTH-1:0] ctr,
                                                    input logic                 taken);
    logic [CTR_WIDTH-1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) nxt = ctr + CTR_ONE;
    end else begin
      if (ctr != CTR_ZERO) nxt = ctr - CTR_ONE;
    end
    return nxt;
  endfunction

  function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] cnt);
    logic [STAT_WIDTH-1:0] nxt;
    nxt = cnt;
    if (cnt != STAT_MAX) nxt = cnt + STAT_ONE;
    return nxt;
  endfunction

  logic [CTR_WIDTH-1:0] ctr_tbl [ENTRIES];
  logic [IDX_W-1:0]     guess_idx;
  logic [IDX_W-1:0]     check_idx;
  logic                 upd;

  assign upd = check_valid & bp_enable;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] hist_q;

  assign guess_idx = guess_pc[IDX_W+1:2] ^ hist_q;
  assign check_idx = check_pc[IDX_W+1:2] ^ hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else if (upd) begin
      hist_q <= {hist_q[IDX_W-2:0], check_taken};
    end
  end
`else
  assign guess_idx = guess_pc[IDX_W+1:2];
  assign check_idx = check_pc[IDX_W+1:2];
`endif

  // PC bits outside the index field play no part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{guess_pc[31:IDX_W+2], guess_pc[1:0],
                            check_pc[31:IDX_W+2], check_pc[1:0]};

  // Reads see the pre-update table, so a same-cycle collision returns the old counter.
  assign guess_taken = bp_enable & guess_valid & ctr_tbl[guess_idx][CTR_WIDTH-1];
  assign mispredict  = check_valid & bp_enable & (check_taken != check_pred);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_tbl[i] <= CTR_WEAK_NT;
      end
    end else if (upd) begin
      ctr_tbl[check_idx] <= ctr_next(ctr_tbl[check_idx], check_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd) begin
      stat_branches <= stat_inc(stat_branches);
      if (mispredict) stat_mispredicts <= stat_inc(stat_mispredicts);
    end
  end

  a_guess_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    guess_taken |-> (guess_valid && bp_enable));
  a_mispredict_needs_enable: assert property (@(posedge clk) disable iff (!rst_n)
    mispredict |-> (check_valid && bp_enable));

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (default build, ENTRIES=32, CTR_WIDTH=2).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bp_enable;
  logic [31:0] guess_pc;
  logic        guess_valid;
  logic        guess_taken;
  logic [31:0] check_pc;
  logic        check_valid;
  logic        check_taken;
  logic        check_pred;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(32), .CTR_WIDTH(2), .STAT_WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bp_enable        (bp_enable),
    .guess_pc         (guess_pc),
    .guess_valid      (guess_valid),
    .guess_taken      (guess_taken),
    .check_pc         (check_pc),
    .check_valid      (check_valid),
    .check_taken      (check_taken),
    .check_pred       (check_pred),
    .mispredict       (mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    string       name;
    logic        en;
    logic        gv;
    logic [31:0] gpc;
    logic        cv;
    logic [31:0] cpc;
    logic        ct;
    logic        cp;
    logic        exp_gt;
    logic        exp_mp;
    int          exp_br;
    int          exp_mc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic en, logic gv, logic [31:0] gpc,
                              logic cv, logic [31:0] cpc, logic ct, logic cp,
                              logic exp_gt, logic exp_mp, int exp_br, int exp_mc);
    vec_t v;
    v.name = name; v.en = en; v.gv = gv; v.gpc = gpc;
    v.cv = cv; v.cpc = cpc; v.ct = ct; v.cp = cp;
    v.exp_gt = exp_gt; v.exp_mp = exp_mp; v.exp_br = exp_br; v.exp_mc = exp_mc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic gv, input logic [31:0] gpc,
                       input logic cv, input logic [31:0] cpc, input logic ct, input logic cp);
    bp_enable = en; guess_valid = gv; guess_pc = gpc;
    check_valid = cv; check_pc = cpc; check_taken = ct; check_pred = cp;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Row expectations describe outputs before that row's clock edge.
    // 0x100, 0x180 and 0x200 share index 0; 0x104 is index 1.
    vecs.push_back(mk("idle_0x100",     1, 1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_0x100",       1, 1, 32'h100, 1, 32'h100, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("t2_0x100",       1, 1, 32'h100, 1, 32'h100, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk("t3_0x100",       1, 1, 32'h100, 1, 32'h100, 1, 1, 1, 0, 2, 1));
    vecs.push_back(mk("alias_0x180",    1, 1, 32'h180, 0, 32'h0,   0, 0, 1, 0, 3, 1));
    vecs.push_back(mk("other_0x104",    1, 1, 32'h104, 0, 32'h0,   0, 0, 0, 0, 3, 1));
    vecs.push_back(mk("nt1_0x100",      1, 1, 32'h100, 1, 32'h100, 0, 1, 1, 1, 3, 1));
    vecs.push_back(mk("hyst_0x100",     1, 1, 32'h100, 0, 32'h0,   0, 0, 1, 0, 4, 2));
    vecs.push_back(mk("nt2_0x100",      1, 1, 32'h100, 1, 32'h100, 0, 1, 1, 1, 4, 2));
    vecs.push_back(mk("after_nt2",      1, 1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 5, 3));
    vecs.push_back(mk("nt3_0x100",      1, 0, 32'h100, 1, 32'h100, 0, 0, 0, 0, 5, 3));
    vecs.push_back(mk("nt4_sat_zero",   1, 1, 32'h100, 1, 32'h100, 0, 0, 0, 0, 6, 3));
    vecs.push_back(mk("t_from_zero",    1, 1, 32'h100, 1, 32'h100, 1, 0, 0, 1, 7, 3));
    vecs.push_back(mk("t_from_one",     1, 1, 32'h100, 1, 32'h100, 1, 0, 0, 1, 8, 4));
    vecs.push_back(mk("after_zero_sat", 1, 1, 32'h100, 0, 32'h0,   0, 0, 1, 0, 9, 5));
    vecs.push_back(mk("guess_invalid",  1, 0, 32'h100, 0, 32'h0,   0, 0, 0, 0, 9, 5));
    vecs.push_back(mk("dis_nt",         0, 1, 32'h100, 1, 32'h100, 0, 1, 0, 0, 9, 5));
    vecs.push_back(mk("dis_nt2",        0, 1, 32'h100, 1, 32'h100, 0, 1, 0, 0, 9, 5));
    vecs.push_back(mk("reenable",       1, 1, 32'h100, 0, 32'h0,   0, 0, 1, 0, 9, 5));

    rst_n = 1'b0;
    drive(1, 1, 32'h100, 0, 32'h0, 0, 0);
    #12;
    chk("rst_guess_taken", {31'd0, guess_taken}, 32'd0);
    chk("rst_branches", stat_branches, 32'd0);
    chk("rst_mispredicts", stat_mispredicts, 32'd0);
    #5 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].gv, vecs[i].gpc, vecs[i].cv, vecs[i].cpc, vecs[i].ct, vecs[i].cp);
      #1;
      chk({vecs[i].name, "_gt"}, {31'd0, guess_taken}, {31'd0, vecs[i].exp_gt});
      chk({vecs[i].name, "_mp"}, {31'd0, mispredict}, {31'd0, vecs[i].exp_mp});
      chk({vecs[i].name, "_br"}, stat_branches, vecs[i].exp_br);
      chk({vecs[i].name, "_mc"}, stat_mispredicts, vecs[i].exp_mc);
      tick();
    end

    // Asynchronous reset between edges after updates: counter 10 at index 0, stats 9/5.
    drive(1, 1, 32'h100, 0, 32'h0, 0, 0);
    #1;
    chk("pre_async_gt", {31'd0, guess_taken}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_gt", {31'd0, guess_taken}, 32'd0);
    chk("async_rst_br", stat_branches, 32'd0);
    chk("async_rst_mc", stat_mispredicts, 32'd0);
    // An edge seen while reset is held must not update.
    drive(1, 1, 32'h100, 1, 32'h100, 1, 0);
    tick();
    tick();
    drive(1, 1, 32'h100, 0, 32'h0, 0, 0);
    #1 rst_n = 1'b1;
    #1;
    chk("held_rst_br", stat_branches, 32'd0);
    tick();
    drive(1, 1, 32'h100, 1, 32'h100, 1, 1);
    #1;
    chk("held_rst_gt", {31'd0, guess_taken}, 32'd0);
    tick();
    drive(1, 1, 32'h100, 0, 32'h0, 0, 0);
    #1;
    chk("post_rst_upd_gt", {31'd0, guess_taken}, 32'd1);
    chk("post_rst_upd_br", stat_branches, 32'd1);

    // Fresh reset, then same-cycle guess/check collision at 0x200.
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    drive(1, 1, 32'h200, 1, 32'h200, 1, 0);
    #1;
    chk("collide_old_gt", {31'd0, guess_taken}, 32'd0);
    chk("collide_mp", {31'd0, mispredict}, 32'd1);
    tick();
    drive(1, 1, 32'h200, 0, 32'h0, 0, 0);
    #1;
    chk("collide_new_gt", {31'd0, guess_taken}, 32'd1);

    // Statistics: 10 resolved branches on indices 16..25, first 3 mispredicted.
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h0, 1, 32'h40 + 32'(4 * i), i[0], (i < 3) ? ~i[0] : i[0]);
      tick();
    end
    drive(1, 0, 32'h0, 0, 32'h0, 0, 0);
    #1;
    chk("stats_branches", stat_branches, 32'd10);
    chk("stats_mispredicts", stat_mispredicts, 32'd3);

    // Disabled: check pulses at 0x200 must not move the table or statistics.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h200, 1, 32'h200, 1, 0);
      #1;
      if (i == 0) chk("dis_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
    end
    drive(1, 1, 32'h200, 0, 32'h0, 0, 0);
    #1;
    chk("dis_branches", stat_branches, 32'd10);
    chk("dis_mispredicts", stat_mispredicts, 32'd3);
    chk("dis_table_frozen", {31'd0, guess_taken}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
